// File: rtl/lcd_frame_latch.sv
// Rebuilds a static 4x32 LCD segment frame (plus Bs per common) from the SM510 multiplexed outputs.
// Optional per-segment persistence is enabled by defining LCD_FADE_EN.
module lcd_frame_latch #(
   parameter int unsigned SETTLE  = 4,
   parameter int unsigned TIMEOUT = 24'hFFFFFF
`ifdef LCD_FADE_EN
   ,parameter int unsigned FADE_FRAMES = 3
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  H,
   input  logic [15:0] segA,
   input  logic [15:0] segB,
   input  logic        Bs,
   input  logic [6:0]  rd_addr,
   output logic        rd_data,
   output logic [3:0]  bs_frame,
   output logic        frame_stb,
   output logic        blank
);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE} state_t;

   localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE - 1);
   localparam logic [23:0] TO_MAX      = 24'(TIMEOUT);

   state_t             state, state_next;
   logic [7:0]         settle_cnt, settle_next;
   logic [1:0]         cap_idx, cap_idx_next;
   logic [3:0]         h_prev;
   logic               h_change, h_valid;
   logic [1:0]         h_idx;
   logic [3:0]         seen;
   logic [3:0][31:0]   shadow, shadow_merged;
   logic [3:0]         shadow_bs, bs_merged;
   logic [127:0]       frame_new, disp_vec;
   logic [23:0]        to_cnt, to_next;
   logic               timeout_hit, capture, commit;

   always_comb begin
      h_change = (H != h_prev);
      h_valid  = (H != 4'd0) && ((H & (H - 4'd1)) == 4'd0);
      case (H)
         4'b0010: h_idx = 2'd1;
         4'b0100: h_idx = 2'd2;
         4'b1000: h_idx = 2'd3;
         default: h_idx = 2'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         settle_cnt <= 8'd0;
         cap_idx    <= 2'd0;
      end else begin
         state      <= state_next;
         settle_cnt <= settle_next;
         cap_idx    <= cap_idx_next;
      end
   end

   // Any change of H during settling either restarts with the new common or abandons the capture.
   always_comb begin
      state_next   = state;
      settle_next  = settle_cnt;
      cap_idx_next = cap_idx;
      case (state)
         ST_IDLE: begin
            if (h_change && h_valid) begin
               state_next   = ST_SETTLE;
               settle_next  = SETTLE_LOAD;
               cap_idx_next = h_idx;
            end
         end
         ST_SETTLE: begin
            if (h_change) begin
               if (h_valid) begin
                  settle_next  = SETTLE_LOAD;
                  cap_idx_next = h_idx;
               end else begin
                  state_next = ST_IDLE;
               end
            end else if (settle_cnt == 8'd0) begin
               state_next = ST_CAPTURE;
            end else begin
               settle_next = settle_cnt - 8'd1;
            end
         end
         ST_CAPTURE: state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      capture       = (state == ST_CAPTURE);
      commit        = capture && ((seen | (4'b0001 << cap_idx)) == 4'hF);
      shadow_merged = shadow;
      shadow_merged[cap_idx] = {segB, segA};
      bs_merged     = shadow_bs;
      bs_merged[cap_idx] = Bs;
      frame_new     = shadow_merged;
      if (h_change && h_valid)
         to_next = 24'd0;
      else if (to_cnt == TO_MAX)
         to_next = to_cnt;
      else
         to_next = to_cnt + 24'd1;
      timeout_hit = (to_next == TO_MAX);
   end

   // Timeout is applied last so a stale display can never survive it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         h_prev    <= 4'd0;
         shadow    <= '0;
         shadow_bs <= 4'd0;
         seen      <= 4'd0;
         bs_frame  <= 4'd0;
         frame_stb <= 1'b0;
         blank     <= 1'b1;
         to_cnt    <= 24'd0;
      end else begin
         h_prev    <= H;
         to_cnt    <= to_next;
         frame_stb <= commit && !timeout_hit;
         if (capture) begin
            shadow    <= shadow_merged;
            shadow_bs <= bs_merged;
            seen      <= commit ? 4'd0 : (seen | (4'b0001 << cap_idx));
         end
         if (commit) begin
            bs_frame <= bs_merged;
            blank    <= 1'b0;
         end
         if (timeout_hit) begin
            blank    <= 1'b1;
            bs_frame <= 4'd0;
            seen     <= 4'd0;
         end
      end
   end

`ifdef LCD_FADE_EN
   localparam logic [2:0] FADE_LOAD = 3'(FADE_FRAMES);

   logic [2:0] fade_cnt [128];

   always_ff @(posedge clk) begin
      if (!rst || timeout_hit) begin
         for (int i = 0; i < 128; i++) fade_cnt[i] <= 3'd0;
      end else if (commit) begin
         for (int i = 0; i < 128; i++) begin
            if (frame_new[i])
               fade_cnt[i] <= FADE_LOAD;
            else if (fade_cnt[i] != 3'd0)
               fade_cnt[i] <= fade_cnt[i] - 3'd1;
         end
      end
   end

   always_comb begin
      disp_vec = '0;
      for (int i = 0; i < 128; i++) disp_vec[i] = (fade_cnt[i] != 3'd0);
   end
`else
   logic [127:0] display;

   always_ff @(posedge clk) begin
      if (!rst || timeout_hit)
         display <= '0;
      else if (commit)
         display <= frame_new;
   end

   assign disp_vec = display;
`endif

   // rd_addr is {common, seg}, which is exactly the flat bit index.
   always_ff @(posedge clk) begin
      if (!rst)
         rd_data <= 1'b0;
      else
         rd_data <= disp_vec[rd_addr];
   end

endmodule
